seg7_bank_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_hex_decoder.sv | 14 +
 rtl/seg7_bank_ctrl.sv | 136 +++++++++++++
 tb/tb_seg7_bank_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment register bank:
// hex glyph table, CTRL bit positions and register offsets.
package seg7_pkg;

    localparam int CTRL_DECODE   = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_INVERT   = 2;

    localparam logic [2:0] CTRL_RESET = 3'b100;

    // Segment order g..a with a in bit 0; 1 = segment lit.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            4'hF:    glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
        return glyph;
    endfunction

    function automatic int ctrl_offset(input int num_digits);
        return num_digits;
    endfunction

    function automatic int blink_div_offset(input int num_digits);
        return num_digits + 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph lookup.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Table lookup shared with the package so every digit uses one glyph set.
    always_comb begin
        glyph = hex_glyph(nibble);
    end

endmodule

// File: rtl/seg7_bank_ctrl.sv
// Avalon-MM register bank driving NUM_DIGITS seven-segment displays with
// optional hex decode, output inversion and a programmable blink prescaler.
module seg7_bank_ctrl
    import seg7_pkg::*;
#(
    parameter int          NUM_DIGITS        = 6,
    parameter int          ADDR_W            = 4,
    parameter logic [31:0] DEFAULT_BLINK_DIV = 32'd25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] seg_out
);

    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_offset(NUM_DIGITS));
    localparam logic [ADDR_W-1:0] DIV_ADDR  = ADDR_W'(blink_div_offset(NUM_DIGITS));

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 14 || NUM_DIGITS + 2 > 2 ** ADDR_W) begin : g_bad_cfg
            $error("seg7_bank_ctrl: NUM_DIGITS must be 1..14 and fit with CTRL/BLINK_DIV in ADDR_W");
        end
    endgenerate

    logic                    we_s;
    logic [6:0]              digit_r [NUM_DIGITS];
    logic [6:0]              glyph_s [NUM_DIGITS];
    logic [2:0]              ctrl_r;
    logic [31:0]             blink_div_r;
    logic [31:0]             blink_cnt_r;
    logic                    blink_phase_r;
    logic [6:0]              digit_rd_s;
    logic [7*NUM_DIGITS-1:0] seg_next_s;
    logic [7*NUM_DIGITS-1:0] seg_r;

    assign we_s = chipselect & ~write_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
            seg7_hex_decoder u_dec (
                .nibble (digit_r[gi][3:0]),
                .glyph  (glyph_s[gi])
            );
        end
    endgenerate

    // Register bank write port; unmapped addresses fall through untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_r[i] <= 7'd0;
            end
            ctrl_r      <= CTRL_RESET;
            blink_div_r <= DEFAULT_BLINK_DIV;
        end else if (we_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == ADDR_W'(i)) begin
                    digit_r[i] <= writedata[6:0];
                end
            end
            if (address == CTRL_ADDR) begin
                ctrl_r <= writedata[2:0];
            end
            if (address == DIV_ADDR) begin
                blink_div_r <= writedata;
            end
        end
    end

    // Blink prescaler; a BLINK_DIV write restarts the period and wins over a reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_r   <= DEFAULT_BLINK_DIV;
            blink_phase_r <= 1'b0;
        end else if (we_s && address == DIV_ADDR) begin
            blink_cnt_r   <= writedata;
            blink_phase_r <= 1'b0;
        end else if (blink_cnt_r == 32'd0) begin
            blink_cnt_r   <= blink_div_r;
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r - 32'd1;
        end
    end

    // Readback mux, zero-extended stored values.
    always_comb begin
        digit_rd_s = 7'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_rd_s = digit_rd_s | ((address == ADDR_W'(i)) ? digit_r[i] : 7'd0);
        end
        if (address < ADDR_W'(NUM_DIGITS)) begin
            readdata = {25'd0, digit_rd_s};
        end else if (address == CTRL_ADDR) begin
            readdata = {29'd0, ctrl_r};
        end else if (address == DIV_ADDR) begin
            readdata = blink_div_r;
        end else begin
            readdata = 32'd0;
        end
    end

    // Glyph select, blink blanking and polarity per digit.
    always_comb begin
        logic [6:0] lit_v;
        lit_v      = 7'd0;
        seg_next_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ctrl_r[CTRL_BLINK_EN] && blink_phase_r) begin
                lit_v = 7'h00;
            end else if (ctrl_r[CTRL_DECODE]) begin
                lit_v = glyph_s[i];
            end else begin
                lit_v = digit_r[i];
            end
            seg_next_s[7*i +: 7] = ctrl_r[CTRL_INVERT] ? ~lit_v : lit_v;
        end
    end

    // Output register; resets to all ones so active-low displays stay dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r <= '1;
        end else begin
            seg_r <= seg_next_s;
        end
    end

    assign seg_out = seg_r;

endmodule

// File: tb/tb_seg7_bank_ctrl.sv
// Randomized scoreboard bench for seg7_bank_ctrl against an event-based
// reference model of the register bank, glyphs and blink timing.
module tb_seg7_bank_ctrl;

    localparam int          ND      = 6;
    localparam int          AW      = 4;
    localparam logic [31:0] DEF_DIV = 32'd25000000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   address = '0;
    logic            chipselect = 1'b0;
    logic            write_n = 1'b1;
    logic [31:0]     writedata = 32'd0;
    logic [31:0]     readdata;
    logic [7*ND-1:0] seg_out;

    always #5 clk = ~clk;

    seg7_bank_ctrl #(
        .NUM_DIGITS        (ND),
        .ADDR_W            (AW),
        .DEFAULT_BLINK_DIV (DEF_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_out    (seg_out)
    );

    // Reference model: blink expressed as absolute edge numbers of the next toggle.
    logic [6:0]      glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0]      m_digit [ND];
    logic [2:0]      m_ctrl;
    logic [31:0]     m_div;
    bit              m_phase;
    longint          m_k;
    longint          m_next_toggle;
    logic [7*ND-1:0] m_seg;

    function automatic logic [7*ND-1:0] m_view();
        logic [7*ND-1:0] v;
        logic [6:0]      g;
        v = '0;
        for (int i = 0; i < ND; i++) begin
            g = m_ctrl[0] ? glyph_tab[m_digit[i][3:0]] : m_digit[i];
            if (m_ctrl[1] && m_phase) g = 7'h00;
            v[7*i +: 7] = m_ctrl[2] ? ~g : g;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a < ND) return {25'd0, m_digit[a]};
        if (a == ND) return {29'd0, m_ctrl};
        if (a == ND + 1) return m_div;
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ND; i++) m_digit[i] = 7'd0;
        m_ctrl        = 3'b100;
        m_div         = DEF_DIV;
        m_phase       = 1'b0;
        m_k           = 0;
        m_next_toggle = longint'(DEF_DIV) + 1;
        m_seg         = '1;
    endtask

    task automatic m_edge(input bit w, input int a, input logic [31:0] d);
        m_seg = m_view();
        m_k++;
        if (w && a == ND + 1) begin
            m_phase       = 1'b0;
            m_next_toggle = m_k + longint'(d) + 1;
        end else if (m_k == m_next_toggle) begin
            m_phase       = ~m_phase;
            m_next_toggle = m_k + longint'(m_div) + 1;
        end
        if (w) begin
            if (a < ND) m_digit[a] = d[6:0];
            else if (a == ND) m_ctrl = d[2:0];
            else if (a == ND + 1) m_div = d;
        end
    endtask

    // Scoreboard: expectations queued by stimulus, consumed by the monitor.
    int              q_kind [$];
    logic [7*ND-1:0] q_exp [$];
    string           q_tag [$];
    int              n_checks = 0;
    int              n_fail = 0;

    task automatic expect_item(input int kind, input logic [7*ND-1:0] exp, input string tag);
        q_kind.push_back(kind);
        q_exp.push_back(exp);
        q_tag.push_back(tag);
    endtask

    always @(negedge clk) begin : monitor
        int              kind;
        logic [7*ND-1:0] e;
        logic [7*ND-1:0] act;
        string           t;
        while (q_kind.size() != 0) begin
            kind = q_kind.pop_front();
            e    = q_exp.pop_front();
            t    = q_tag.pop_front();
            act  = (kind == 0) ? seg_out : {10'd0, readdata};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", t, act, e, $time);
            end
        end
    end

    // One bus cycle; called just after a rising edge.
    task automatic cyc(input bit cs, input bit wn, input int a, input logic [31:0] d,
                       input bit chk_rd, input string tag);
        chipselect = cs;
        write_n    = wn;
        address    = AW'(a);
        writedata  = d;
        expect_item(0, m_seg, {tag, "/seg"});
        if (chk_rd) expect_item(1, {10'd0, m_read(a)}, {tag, "/rd"});
        @(posedge clk);
        m_edge(cs & ~wn, a, d);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input string tag);
        cyc(1'b1, 1'b0, a, d, 1'b1, tag);
    endtask

    task automatic rd(input int a, input string tag);
        cyc(1'b1, 1'b1, a, 32'd0, 1'b1, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, ND, 32'd0, 1'b1, tag);
    endtask

    task automatic reset_midrun();
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = AW'(ND);
        #1;
        expect_item(0, '1, "rst/seg");
        expect_item(1, {10'd0, 32'h4}, "rst/ctrl");
        @(posedge clk);
        #1;
        address = AW'(ND + 1);
        expect_item(0, '1, "rst/seg2");
        expect_item(1, {10'd0, DEF_DIV}, "rst/div");
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        int guard;
        int r;
        int a;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();

        rd(ND, "init_ctrl");
        rd(ND + 1, "init_div");
        rd(0, "init_d0");
        rd(ND + 2, "init_unmapped");

        wr(2, 32'h5B, "raw_d2");
        wr(ND, 32'h0, "raw_ctrl");
        idle(2, "raw_wait");
        rd(2, "raw_rb");

        wr(ND, 32'h5, "dec_ctrl");
        wr(0, 32'h7A, "dec_d0");
        idle(2, "dec_wait");
        rd(0, "dec_rb");

        wr(ND + 1, 32'd3, "blk_div");
        wr(ND, 32'h3, "blk_ctrl");
        wr(1, 32'h7F, "blk_d1");
        idle(14, "blk_run");
        guard = 0;
        while (!m_phase && guard < 50) begin
            idle(1, "blk_wait_dark");
            guard++;
        end
        wr(ND + 1, 32'd3, "blk_rewrite");
        idle(4, "blk_after");

        wr(ND + 1, 32'd0, "div0");
        idle(6, "div0_run");

        reset_midrun();
        idle(2, "post_rst");

        wr(ND + 2, 32'hFFFF_FFFF, "oob_wr");
        wr(15, 32'hFFFF_FFFF, "oob_wr15");
        rd(ND + 2, "oob_rd");
        for (int i = 0; i < ND + 2; i++) rd(i, "oob_regs");

        wr(ND, 32'h3, "col_ctrl");
        wr(3, 32'h66, "col_d3");
        wr(ND + 1, 32'd5, "col_div5");
        guard = 0;
        while (m_next_toggle != m_k + 1 && guard < 100) begin
            idle(1, "col_wait");
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL col_align: waited %0d cycles, required < 100", guard);
        end
        wr(ND + 1, 32'd10, "col_div10");
        idle(25, "col_run");

        for (int i = 0; i < 600; i++) begin
            if (i == 300) reset_midrun();
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            if (r <= 3) begin
                if (a == ND + 1) wr(a, 32'($urandom_range(0, 6)), "rnd_wr");
                else wr(a, $urandom, "rnd_wr");
            end else if (r == 4) begin
                cyc(1'b0, 1'b0, a, $urandom, 1'b1, "rnd_nocs");
            end else begin
                rd(a, "rnd_rd");
            end
        end

        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
